key_seq_master: RTL

- Bus-side sequencer that drives the serial key/sequence-lock device on the shared bus and consumes its SDRD data line.
- It takes a stream of 4-bit address nibbles from the host controller and issues one qualified read access per nibble: SSER low, BA13=0, BA12=1, BR_W=1, BA7..BA4=nibble.
- It samples SDRD at the end of each access and assembles the bits into an NBITS-wide response word, which it returns over a valid/ready handshake.

---
 rtl/key_seq_master.sv | 132 +++++++++++++
 1 files changed

// File: rtl/key_seq_master.sv
// Bus-side sequencer for the serial key/sequence-lock device: one select pulse per host
// nibble, SDRD sampled at the end of each strobe and returned as an NBITS-wide word.
//
// Handshakes: nib_valid/nib_ready and resp_valid/resp_ready transfer on a rising edge where
// both are high; valid may not depend on ready; nib_ready and resp_valid derive from state
// (nib_ready is also masked by abort), so no ready->valid loop exists.
module key_seq_master #(
   parameter int NBITS      = 16,
   parameter int STROBE_CYC = 2,
   parameter int RECOV_CYC  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             nib_valid,
   input  logic [3:0]       nib_data,
   output logic             nib_ready,
   output logic             SSER,
   output logic             BA13,
   output logic             BA12,
   output logic [3:0]       BA7_4,
   output logic             BR_W,
   input  logic             SDRD,
   output logic             resp_valid,
   output logic [NBITS-1:0] resp_data,
   input  logic             resp_ready,
   output logic             busy
);

   localparam int CW = $clog2(NBITS + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_SETUP  = 3'd2,
      S_STROBE = 3'd3,
      S_RECOV  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    bit_cnt;
   logic [3:0]       timer;
   logic [NBITS-1:0] shreg;
   logic             strobe_last, recov_last, last_bit;

   assign strobe_last = (timer == 4'(STROBE_CYC - 1));
   assign recov_last  = (timer == 4'(RECOV_CYC - 1));
   assign last_bit    = (bit_cnt == CW'(NBITS - 1));

   assign nib_ready  = (state == S_FETCH) && !abort;
   assign resp_valid = (state == S_DONE);
   assign busy       = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:   if (start)       state_nxt = S_FETCH;
            S_FETCH:  if (nib_valid)   state_nxt = S_SETUP;
            S_SETUP:                   state_nxt = S_STROBE;
            S_STROBE: if (strobe_last) state_nxt = S_RECOV;
            S_RECOV:  if (recov_last)  state_nxt = last_bit ? S_DONE : S_FETCH;
            S_DONE:   if (resp_ready)  state_nxt = S_IDLE;
            default:                   state_nxt = S_IDLE;
         endcase
      end
   end

   // Bus pins are registered; the device sees the address settle one cycle before SSER falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         SSER      <= 1'b1;
         BA13      <= 1'b1;
         BA12      <= 1'b0;
         BR_W      <= 1'b0;
         BA7_4     <= 4'd0;
         bit_cnt   <= '0;
         timer     <= 4'd0;
         shreg     <= '0;
         resp_data <= '0;
      end else begin
         timer <= ((state_nxt == state) && (state == S_STROBE || state == S_RECOV))
                  ? timer + 4'd1 : 4'd0;
         if (abort) begin
            SSER  <= 1'b1;
            BA13  <= 1'b1;
            BA12  <= 1'b0;
            BR_W  <= 1'b0;
            BA7_4 <= 4'd0;
         end else begin
            case (state)
               S_IDLE: if (start) begin
                  bit_cnt   <= '0;
                  shreg     <= '0;
                  resp_data <= '0;
               end
               S_FETCH: if (nib_valid) begin
                  BA7_4 <= nib_data;
                  BA13  <= 1'b0;
                  BA12  <= 1'b1;
                  BR_W  <= 1'b1;
               end
               S_SETUP: SSER <= 1'b0;
               // Right shift lands the first sampled bit in bit 0 after NBITS accesses.
               S_STROBE: if (strobe_last) begin
                  SSER  <= 1'b1;
                  shreg <= {SDRD, shreg[NBITS-1:1]};
               end
               S_RECOV: if (recov_last) begin
                  BA13    <= 1'b1;
                  BA12    <= 1'b0;
                  BR_W    <= 1'b0;
                  BA7_4   <= 4'd0;
                  bit_cnt <= bit_cnt + CW'(1);
                  if (last_bit) resp_data <= shreg;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
